// File: rtl/stream_merger.sv
// Two-to-one valid/ready merger: bounded-burst round-robin arbitration into a registered master stream.
// Master identity is {source port, slave identity}; one cycle latency, one beat per cycle.
module stream_merger #(
  parameter int identity_width = 2,
  parameter int stream_width   = 32,
  parameter int max_burst      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      axi_s_0_ready,
  input  logic                      axi_s_0_valid,
  input  logic [identity_width-1:0] axi_s_0_identity,
  input  logic [stream_width-1:0]   axi_s_0_stream,
  output logic                      axi_s_1_ready,
  input  logic                      axi_s_1_valid,
  input  logic [identity_width-1:0] axi_s_1_identity,
  input  logic [stream_width-1:0]   axi_s_1_stream,
  input  logic                      axi_m_ready,
  output logic                      axi_m_valid,
  output logic [identity_width:0]   axi_m_identity,
  output logic [stream_width-1:0]   axi_m_stream
);

  localparam int count_width = (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  localparam logic [count_width-1:0] burst_limit = count_width'(max_burst);
  localparam logic [count_width-1:0] count_one   = count_width'(1);

  logic                      slot_free;
  logic                      grant_valid;
  logic                      grant_port;
  logic                      take;
  logic [identity_width-1:0] sel_identity;
  logic [stream_width-1:0]   sel_stream;

  logic                      last;
  logic                      holder_valid;
  logic                      holder_port;
  logic [count_width-1:0]    count;

  assign slot_free = !axi_m_valid || axi_m_ready;

  // The holder keeps a contended grant until its burst is used up, then the other port gets it.
  always_comb begin
    grant_valid = axi_s_0_valid || axi_s_1_valid;
    grant_port  = 1'b0;
    if (axi_s_0_valid && axi_s_1_valid) begin
      if (holder_valid && (count < burst_limit)) begin
        grant_port = holder_port;
      end else begin
        grant_port = !last;
      end
    end else begin
      grant_port = axi_s_1_valid;
    end
  end

  assign take          = !reset && slot_free && grant_valid;
  assign axi_s_0_ready = take && !grant_port;
  assign axi_s_1_ready = take && grant_port;

  assign sel_identity = grant_port ? axi_s_1_identity : axi_s_0_identity;
  assign sel_stream   = grant_port ? axi_s_1_stream   : axi_s_0_stream;

  always_ff @(posedge clock) begin
    if (reset) begin
      axi_m_valid    <= 1'b0;
      axi_m_identity <= '0;
      axi_m_stream   <= '0;
      last           <= 1'b1;
      holder_valid   <= 1'b0;
      holder_port    <= 1'b0;
      count          <= '0;
    end else if (take) begin
      axi_m_valid    <= 1'b1;
      axi_m_identity <= {grant_port, sel_identity};
      axi_m_stream   <= sel_stream;
      last           <= grant_port;
      holder_valid   <= 1'b1;
      holder_port    <= grant_port;
      if (holder_valid && (holder_port == grant_port)) begin
        count <= (count >= burst_limit) ? burst_limit : count + count_one;
      end else begin
        count <= count_one;
      end
    end else begin
      // Any cycle without a transfer ends the current burst.
      if (slot_free) begin
        axi_m_valid <= 1'b0;
      end
      holder_valid <= 1'b0;
      count        <= '0;
    end
  end

endmodule
